// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the loader/debug port, the instruction
// memory and imem_port_arbiter. The arbiter uses the slave modport.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_flush;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  logic              f_err;

  logic              l_req;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic              l_lock;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;
  logic              l_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  f_req, f_addr, f_flush,
    input  l_req, l_we, l_addr, l_wdata, l_lock,
    input  mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, f_flush,
    output l_req, l_we, l_addr, l_wdata, l_lock,
    output mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the instruction-memory port between fetch (F) and loader (L).
// Optional macro ARB_RR_EN: round-robin IDLE ties (default: F wins ties).
module imem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int LOCK_MAX = 16
) (
  input  logic                clka,
  input  logic                rst_n,
  imem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK   = 2'd1;
  localparam logic [1:0] STARVE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             f_bad, l_bad;
  logic             f_gnt, l_gnt;
  logic             tie_to_f;

  assign f_bad = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr[31:ADDR_W+2] != '0);
  assign l_bad = (bus.l_addr[1:0] != 2'b00) || (bus.l_addr[31:ADDR_W+2] != '0);

`ifdef ARB_RR_EN
  // last_win: 1 = L won the most recent grant
  logic last_win;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n)     last_win <= 1'b1;
    else if (f_gnt) last_win <= 1'b0;
    else if (l_gnt) last_win <= 1'b1;
  end

  assign tie_to_f = last_win;
`else
  assign tie_to_f = 1'b1;
`endif

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    case (state)
      LOCK:   l_gnt = bus.l_req;
      STARVE: begin
        f_gnt = bus.f_req;
        l_gnt = bus.l_req & ~bus.f_req;
      end
      default: begin
        if (bus.f_req && bus.l_req) begin
          f_gnt = tie_to_f;
          l_gnt = ~tie_to_f;
        end else begin
          f_gnt = bus.f_req;
          l_gnt = bus.l_req;
        end
      end
    endcase
  end

  // A loader release takes precedence over the starvation cut-off
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      IDLE: begin
        if (l_gnt && bus.l_lock) begin
          state_nxt    = LOCK;
          lock_cnt_nxt = CNT_W'(1);
        end
      end
      LOCK: begin
        lock_cnt_nxt = lock_cnt + 1'b1;
        if ((l_gnt && !bus.l_lock) || !bus.l_req) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
          state_nxt = STARVE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  assign bus.f_gnt     = f_gnt;
  assign bus.l_gnt     = l_gnt;
  assign bus.mem_en    = (f_gnt & ~f_bad) | (l_gnt & ~l_bad);
  assign bus.mem_we    = l_gnt & bus.l_we & ~l_bad;
  assign bus.mem_addr  = l_gnt ? bus.l_addr[ADDR_W+1:2] :
                         f_gnt ? bus.f_addr[ADDR_W+1:2] : '0;
  assign bus.mem_wdata = l_gnt ? bus.l_wdata : '0;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      bus.f_rvalid <= 1'b0;
      bus.f_err    <= 1'b0;
      bus.f_rdata  <= '0;
      bus.l_rvalid <= 1'b0;
      bus.l_err    <= 1'b0;
      bus.l_rdata  <= '0;
    end else begin
      bus.f_rvalid <= f_gnt & ~bus.f_flush;
      bus.f_err    <= f_gnt & ~bus.f_flush & f_bad;
      bus.f_rdata  <= (f_gnt && !bus.f_flush && !f_bad) ? bus.mem_rdata : '0;
      bus.l_rvalid <= l_gnt;
      bus.l_err    <= l_gnt & l_bad;
      bus.l_rdata  <= (l_gnt && !bus.l_we && !l_bad) ? bus.mem_rdata : '0;
    end
  end

endmodule
